// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus instruction queue between the instruction ROM and decode.
//
// The block drives the PC register onto pc_o and reads a combinational ROM through instr_i.
// In RUN it writes each fetched {instruction, PC} pair into a DEPTH-entry circular queue.
// The queue head goes to decode over a valid/ready handshake, so a decode stall does not
// stop fetch until the queue is full. start_i loads the PC and flushes the queue. branch_i
// in RUN redirects the PC and also flushes the queue.
//
// Ports
//   clk              rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   start_i          hold PC at start_address_i, flush queue
//   start_address_i  load address while start_i is high
//   branch_i         one-cycle redirect request (honoured in RUN only)
//   branchloc_i      branch target
//   pc_o             ROM address (the PC register)
//   instr_i          ROM data for pc_o, same cycle
//   valid_o          queue head valid
//   ready_i          decode accepts head
//   instr_o          head instruction
//   instr_pc_o       PC of head instruction
//   count_o          queue occupancy
//   running_o        high in RUN
module fetch_queue #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [PC_WIDTH-1:0]          start_address_i,
  input  logic                         branch_i,
  input  logic [PC_WIDTH-1:0]          branchloc_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  input  logic [INSTR_WIDTH-1:0]       instr_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [INSTR_WIDTH-1:0]       instr_o,
  output logic [PC_WIDTH-1:0]          instr_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         running_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]             r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
  logic [PTR_W-1:0]       r_head, w_head_nxt;
  logic [PTR_W-1:0]       r_tail, w_tail_nxt;
  logic [CNT_W-1:0]       r_count, w_count_nxt;

  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];

  logic w_run;
  logic w_pop;
  logic w_branch;
  logic w_push;
  logic w_not_full;

  assign w_run      = (r_state == ST_RUN) && !start_i;
  assign w_pop      = valid_o && ready_i;
  assign w_branch   = w_run && branch_i;
  assign w_not_full = (r_count < CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign w_push     = w_run && !branch_i && (w_not_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (start_i) begin
      w_state_nxt = ST_LOAD;
      w_pc_nxt    = start_address_i;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (r_state == ST_LOAD) begin
        w_state_nxt = ST_RUN;
      end
      if (w_branch) begin
        // A concurrent pop still completes at decode; the flush discards everything else.
        w_pc_nxt    = branchloc_i;
        w_head_nxt  = '0;
        w_tail_nxt  = '0;
        w_count_nxt = '0;
      end else begin
        if (w_push) begin
          w_tail_nxt = r_tail + PTR_W'(1);
          w_pc_nxt   = r_pc + PC_WIDTH'(1);
        end
        if (w_pop) begin
          w_head_nxt = r_head + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   w_count_nxt = r_count + CNT_W'(1);
          2'b01:   w_count_nxt = r_count - CNT_W'(1);
          default: w_count_nxt = r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entries are cleared on reset so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
      end
    end else if (w_push) begin
      r_instr_mem[r_tail] <= instr_i;
      r_pc_mem[r_tail]    <= r_pc;
    end
  end

  assign pc_o       = r_pc;
  assign valid_o    = (r_count != '0);
  assign instr_o    = r_instr_mem[r_head];
  assign instr_pc_o = r_pc_mem[r_head];
  assign count_o    = r_count;
  assign running_o  = (r_state == ST_RUN);

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-register `fetch` stage, sitting between the instruction ROM and decode/control. It generates the PC and reads a combinational instruction ROM each cycle. It buffers fetched instructions together with their PCs in a DEPTH-entry queue, and hands them to decode over a valid/ready handshake, so decode stalls no longer freeze PC generation. Start/load and branch redirect (with queue flush) are preserved from the previous fetch behaviour.

## Interface
- PC_WIDTH, 16, width of PC, start and branch addresses
- INSTR_WIDTH, 9, width of one instruction word from the ROM
- DEPTH, 4, queue entries; power of two, >= 2
- clk  input  1  rising-edge clock
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  while high: hold PC at start_address_i and flush the queue
- start_address_i  input  PC_WIDTH  load address used while start_i is high
- branch_i  input  1  redirect request (one-cycle pulse)
- branchloc_i  input  PC_WIDTH  branch target
- pc_o  output  PC_WIDTH  ROM address; the PC register
- instr_i  input  INSTR_WIDTH  ROM data for pc_o, same cycle
- valid_o  output  1  queue head valid
- ready_i  input  1  decode accepts head
- instr_o  output  INSTR_WIDTH  head instruction
- instr_pc_o  output  PC_WIDTH  PC of head instruction
- count_o  output  $clog2(DEPTH+1)  queue occupancy
- running_o  output  1  state == RUN

## Operation
- States:
  - IDLE: entered on reset; no fetch.
  - LOAD: start_i high.
  - RUN: fetching.
- Transitions, evaluated at each edge:
  - Any state with start_i=1 -> LOAD. PC <= start_address_i; queue flushed (count=0).
  - LOAD with start_i=0 -> RUN.
  - RUN with start_i=0 stays RUN. IDLE with start_i=0 stays IDLE.
- Pop: valid_o && ready_i. Head advances; count decrements.
- Push condition: state RUN, start_i=0, branch_i=0, and (count < DEPTH or pop this cycle).
  - {instr_i, pc_o} is written at tail.
  - PC <= PC+1, modulo 2^PC_WIDTH (0xFFFF wraps to 0x0000 at default width).
- PC does not advance in a RUN cycle with no push (queue full and no pop).
- Branch, in RUN with start_i=0:
  - Queue flushed. No push. PC <= branchloc_i.
  - A pop in the same cycle completes; decode has consumed the head.
  - After the flush, count=0 regardless of the pop.
- branch_i in IDLE or LOAD is ignored.
- Priority: start_i > branch_i > push/pop.
- Push and pop in the same cycle: count unchanged, including at count == DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- valid_o = (count != 0).
- instr_o and instr_pc_o come from the head entry and are undefined but stable while valid_o=0.

## Timing
- Reset (rst_n_i low, asynchronous):
  - State = IDLE; pc_o=0; count_o=0; valid_o=0; running_o=0; pointers=0.
  - instr_o and instr_pc_o are 0.
- Deassertion is sampled at the next rising edge. No fetch occurs until start_i has been high for at least one edge.
- pc_o is registered. instr_i is captured at the same edge on which pc_o is presented (zero-wait ROM).
- Latency: if cycle c is the first RUN cycle, pc_o = start_address in c, and valid_o=1 in c+1 with instr_pc_o = start_address.
- Throughput with ready_i held high: one instruction per cycle; count stays 1.
- Branch at edge e:
  - pc_o = branchloc_i from e.
  - valid_o=0 in the cycle after e.
  - First target instruction is valid 2 cycles after e.
- Reset mid-RUN: all state is lost immediately (asynchronous). No partial entries survive.

## Test plan
Use PC_WIDTH=16, DEPTH=4, and a ROM model instr_i = pc_o[8:0] ^ 9'h0A5.
- Reset, then start_i high for 2 cycles with start_address_i=0x0005, then low, ready_i=1 -> valid_o rises one cycle after the first RUN cycle. instr_pc_o then runs 0x0005, 0x0006, 0x0007, … one per cycle, with instr_o matching the ROM model.
- Run with ready_i=0 -> count_o reaches 4 after 4 RUN cycles and pc_o freezes at start+4. Then ready_i=1 -> entries drain in order with no loss or duplication, and count_o stays 4 while push and pop overlap.
- branch_i pulse with branchloc_i=0x000A while 3 entries are queued and ready_i=1 -> count_o=0 the next cycle, pc_o=0x000A, and the next delivered instr_pc_o is 0x000A. No pre-branch PC is delivered after the branch edge.
- start_address_i=0xFFFE, run 4 cycles -> delivered PCs are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start_i and branch_i high in the same cycle with start_address_i=0x0000 and branchloc_i=0x0010 -> LOAD wins: pc_o=0x0000 and the queue is flushed. branch_i while IDLE -> no change in pc_o or count_o.
- rst_n_i low asynchronously mid-RUN, between edges, with count_o=3 -> valid_o, count_o and pc_o drop to 0 immediately, without waiting for an edge. After release, the block stays IDLE until start_i.
